// File: rtl/bullet_object.sv
// Single-bullet projectile: spawns centred above the gun, climbs SPEED px per tick, then cools down.
// Optional macro BULLET_HIT_EN adds a hit input that retires an in-flight bullet immediately.
module bullet_object #(
    parameter int unsigned BULLET_W       = 4,
    parameter int unsigned BULLET_H       = 8,
    parameter int unsigned GUN_W          = 32,
    parameter int unsigned SPEED          = 8,
    parameter int unsigned TOP_BOUND      = 0,
    parameter int unsigned TICK_DIV       = 2500000,
    parameter int unsigned COOLDOWN_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       fire,
    input  logic [9:0] gun_xl,
    input  logic [9:0] gun_yt,
`ifdef BULLET_HIT_EN
    input  logic       hit,
`endif
    output logic       bulletx,
    output logic       bullety,
    output logic       active,
    output logic [9:0] bx,
    output logic [9:0] by,
    output logic       fired
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TICK_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN_TICKS);
    // Offset wraps modulo 1024 exactly like the 10-bit spawn-x sum.
    localparam logic [9:0]       SPAWN_OFS  = 10'(GUN_W / 2 - BULLET_W / 2);
    localparam logic [10:0]      SPAWN_MIN  = 11'(TOP_BOUND + BULLET_H);
    localparam logic [10:0]      RETIRE_LIM = 11'(TOP_BOUND + SPEED);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StFly,
        StCooldown
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             fire_q;
    logic [9:0]       bx_q, bx_d;
    logic [9:0]       by_q, by_d;
    logic             active_q, active_d;
    logic             fired_q, fired_d;
    logic             bulletx_q, bulletx_d;
    logic             bullety_q, bullety_d;

    logic tick;
    logic fire_rise;
    logic hit_in;

`ifdef BULLET_HIT_EN
    assign hit_in = hit;
`else
    assign hit_in = 1'b0;
`endif

    assign tick      = (cnt_q == CNT_MAX);
    assign fire_rise = fire & ~fire_q;

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        bx_d     = bx_q;
        by_d     = by_q;
        active_d = active_q;
        fired_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fire_rise) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                bx_d     = gun_xl + SPAWN_OFS;
                // Clamp at the top boundary when the gun sits too high to spawn fully above it.
                by_d     = ({1'b0, gun_yt} >= SPAWN_MIN) ? gun_yt - 10'(BULLET_H)
                                                         : 10'(TOP_BOUND);
                active_d = 1'b1;
                fired_d  = 1'b1;
                state_d  = StFly;
            end
            StFly: begin
                if (hit_in) begin
                    active_d = 1'b0;
                    cd_d     = CD_LOAD;
                    state_d  = StCooldown;
                end else if (tick) begin
                    if ({1'b0, by_q} < RETIRE_LIM) begin
                        active_d = 1'b0;
                        cd_d     = CD_LOAD;
                        state_d  = StCooldown;
                    end else begin
                        by_d = by_q - 10'(SPEED);
                    end
                end
            end
            StCooldown: begin
                if (cd_q == '0) begin
                    state_d = StIdle;
                end else if (tick) begin
                    cd_d = cd_q - CD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flags use next-cycle position/active so they can never be set while active is low.
    always_comb begin
        bulletx_d = active_d && ({1'b0, x} >= {1'b0, bx_d})
                             && ({1'b0, x} < ({1'b0, bx_d} + 11'(BULLET_W)));
        bullety_d = active_d && ({1'b0, y} >= {1'b0, by_d})
                             && ({1'b0, y} < ({1'b0, by_d} + 11'(BULLET_H)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cd_q      <= '0;
            fire_q    <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            active_q  <= 1'b0;
            fired_q   <= 1'b0;
            bulletx_q <= 1'b0;
            bullety_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cd_q      <= cd_d;
            fire_q    <= fire;
            bx_q      <= bx_d;
            by_q      <= by_d;
            active_q  <= active_d;
            fired_q   <= fired_d;
            bulletx_q <= bulletx_d;
            bullety_q <= bullety_d;
        end
    end

    assign bulletx = bulletx_q;
    assign bullety = bullety_q;
    assign active  = active_q;
    assign bx      = bx_q;
    assign by      = by_q;
    assign fired   = fired_q;

endmodule
